// File: rtl/neosd_rsp_rx.sv
// Receives SD CMD-line responses (48-bit or 136-bit R2) MSB first on clkstrb_i, checks CRC7 and end bit.
// Latency: done_o and flags 1 clk after the strobe that samples the end bit (or the last timeout strobe).
// Backpressure: none; the card drives the line freely, frame and flags hold until the next arm_i.
module neosd_rsp_rx #(
    parameter int TIMEOUT_STRB = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clkstrb_i,
    input  logic         arm_i,
    input  logic         long_i,
    input  logic         abort_i,
    input  logic         cmd_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic [135:0] rsp_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RECV
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_STRB);

    state_t         state_q, state_d;
    logic [135:0]   rsp_q, rsp_d;
    logic [7:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     tocnt_q, tocnt_d;
    logic [6:0]     crc_q, crc_d;
    logic           long_q, long_d;
    logic           done_q, done_d;
    logic           timeout_q, timeout_d;
    logic           crc_err_q, crc_err_d;
    logic           end_err_q, end_err_d;

    logic [7:0]     frame_len;
    logic [7:0]     crc_lo;
    logic [7:0]     crc_hi;
    logic [7:0]     cnt_new;
    logic           crc_fb;
    logic [6:0]     crc_upd;
    logic           in_crc;

    // R2 excludes its 8 header bits from the CRC; short frames include the start bit.
    assign frame_len = long_q ? 8'd136 : 8'd48;
    assign crc_lo    = long_q ? 8'd9 : 8'd1;
    assign crc_hi    = frame_len - 8'd8;
    assign cnt_new   = (state_q == S_WAIT) ? 8'd1 : (bitcnt_q + 8'd1);
    assign crc_fb    = cmd_i ^ crc_q[6];
    assign crc_upd   = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
    assign in_crc    = (cnt_new >= crc_lo) && (cnt_new <= crc_hi);

    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        bitcnt_d  = bitcnt_q;
        tocnt_d   = tocnt_q;
        crc_d     = crc_q;
        long_d    = long_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;

        case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    state_d   = S_WAIT;
                    long_d    = long_i;
                    rsp_d     = '0;
                    bitcnt_d  = '0;
                    tocnt_d   = '0;
                    crc_d     = '0;
                    timeout_d = 1'b0;
                    crc_err_d = 1'b0;
                    end_err_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (clkstrb_i) begin
                    if (!cmd_i) begin
                        rsp_d    = {rsp_q[134:0], cmd_i};
                        bitcnt_d = 8'd1;
                        if (in_crc) begin
                            crc_d = crc_upd;
                        end
                        state_d  = S_RECV;
                    end else begin
                        tocnt_d = tocnt_q + 8'd1;
                        if (tocnt_d == TO_LIM) begin
                            timeout_d = 1'b1;
                            done_d    = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end
            S_RECV: begin
                if (clkstrb_i) begin
                    rsp_d    = {rsp_q[134:0], cmd_i};
                    bitcnt_d = cnt_new;
                    if (in_crc) begin
                        crc_d = crc_upd;
                    end
                    if (cnt_new == frame_len) begin
                        // After this shift, received bits [7:1] are the current rsp_q[6:0].
                        end_err_d = ~cmd_i;
                        crc_err_d = (crc_q != rsp_q[6:0]);
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            rsp_q     <= '0;
            bitcnt_q  <= '0;
            tocnt_q   <= '0;
            crc_q     <= '0;
            long_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            bitcnt_q  <= bitcnt_d;
            tocnt_q   <= tocnt_d;
            crc_q     <= crc_d;
            long_q    <= long_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
        end
    end

    assign busy_o    = (state_q == S_WAIT) || (state_q == S_RECV);
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign crc_err_o = crc_err_q;
    assign end_err_o = end_err_q;
    assign rsp_o     = rsp_q;

endmodule

// File: tb/tb_neosd_rsp_rx.sv
// Bench for neosd_rsp_rx: directed frames, expected completions queued ahead and checked by a done_o monitor.
module tb_neosd_rsp_rx;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         clkstrb_i;
    logic         arm_i;
    logic         long_i;
    logic         abort_i;
    logic         cmd_i;
    logic         busy_o;
    logic         done_o;
    logic         timeout_o;
    logic         crc_err_o;
    logic         end_err_o;
    logic [135:0] rsp_o;

    neosd_rsp_rx #(.TIMEOUT_STRB(64)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clkstrb_i (clkstrb_i),
        .arm_i     (arm_i),
        .long_i    (long_i),
        .abort_i   (abort_i),
        .cmd_i     (cmd_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .timeout_o (timeout_o),
        .crc_err_o (crc_err_o),
        .end_err_o (end_err_o),
        .rsp_o     (rsp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [135:0] rsp;
        logic         to;
        logic         ce;
        logic         ee;
        int           nstrb;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   last_strb = 0;
    int   strb_cnt  = 0;
    int   n_chk     = 0;
    int   n_pass    = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(negedge clk_i) begin
        if (rstn_i === 1'b1 && done_o === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: done_o=1 at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp", rsp_o, e.rsp);
                check("timeout", 136'(timeout_o), 136'(e.to));
                check("crc_err", 136'(crc_err_o), 136'(e.ce));
                check("end_err", 136'(end_err_o), 136'(e.ee));
                check("busy_at_done", 136'(busy_o), 136'(0));
                check("strobe_count_at_done", 136'(strb_cnt), 136'(e.nstrb));
                check("done_latency_cycle", 136'(cyc), 136'(last_strb));
            end
        end
    end

    function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c = '0;
        logic       fb;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic strobe(input logic b);
        cmd_i     = b;
        clkstrb_i = 1'b1;
        @(posedge clk_i);
        #1;
        last_strb = cyc;
        strb_cnt++;
        clkstrb_i = 1'b0;
        cmd_i     = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic arm(input logic lng);
        arm_i  = 1'b1;
        long_i = lng;
        @(posedge clk_i);
        #1;
        arm_i  = 1'b0;
        long_i = 1'b0;
    endtask

    task automatic send_bits(input logic [135:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) strobe(f[i]);
    endtask

    task automatic expect_done(input logic [135:0] r, input logic to, input logic ce, input logic ee,
                               input int nstrb);
        exp_t e;
        e.rsp = r; e.to = to; e.ce = ce; e.ee = ee; e.nstrb = strb_cnt + nstrb;
        q.push_back(e);
    endtask

    logic [135:0] r2;
    logic [135:0] f1;

    initial begin
        rstn_i = 1'b0; clkstrb_i = 1'b0; arm_i = 1'b0; long_i = 1'b0;
        abort_i = 1'b0; cmd_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", 136'(busy_o), 136'(0));
        check("reset_done", 136'(done_o), 136'(0));
        check("reset_flags", 136'({timeout_o, crc_err_o, end_err_o}), 136'(0));
        check("reset_rsp", rsp_o, 136'(0));
        rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // 1: short frame after 3 idle strobes
        arm(1'b0);
        check("busy_after_arm", 136'(busy_o), 136'(1));
        repeat (3) strobe(1'b1);
        f1 = 136'(48'h400000000095);
        expect_done(f1, 1'b0, 1'b0, 1'b0, 48);
        send_bits(f1, 47, 0);
        repeat (5) @(posedge clk_i);
        #1;
        check("rsp_hold_after_done", rsp_o, f1);

        // 2: CRC field corrupted
        arm(1'b0);
        expect_done(136'(48'h48000001AA85), 1'b0, 1'b1, 1'b0, 48);
        send_bits(136'(48'h48000001AA85), 47, 0);

        // 3: end bit 0
        arm(1'b0);
        expect_done(136'(48'h400000000094), 1'b0, 1'b0, 1'b1, 48);
        send_bits(136'(48'h400000000094), 47, 0);

        // 4: timeout after exactly 64 strobes
        arm(1'b0);
        expect_done(136'(0), 1'b1, 1'b0, 1'b0, 64);
        repeat (64) strobe(1'b1);

        // 5: R2 with valid CRC over [127:8]
        r2 = {8'h3F, 120'h0353445344303447308012345601A3, 8'h01};
        r2[7:1] = crc7(r2, 127, 8);
        arm(1'b1);
        expect_done(r2, 1'b0, 1'b0, 1'b0, 136);
        send_bits(r2, 135, 0);

        // 6: abort mid-frame, arm with coincident strobe, arm while busy
        arm(1'b0);
        strobe(1'b1);
        send_bits(f1, 47, 28);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        check("busy_after_abort", 136'(busy_o), 136'(0));
        check("flags_after_abort", 136'({timeout_o, crc_err_o, end_err_o}), 136'(0));
        repeat (10) @(posedge clk_i);
        #1;
        arm_i = 1'b1; clkstrb_i = 1'b1; cmd_i = 1'b1;
        @(posedge clk_i);
        #1;
        arm_i = 1'b0; clkstrb_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        expect_done(136'(48'h48000001AA87), 1'b0, 1'b0, 1'b0, 63 + 48);
        repeat (10) strobe(1'b1);
        arm(1'b1);
        check("busy_after_ignored_arm", 136'(busy_o), 136'(1));
        repeat (53) strobe(1'b1);
        send_bits(136'(48'h48000001AA87), 47, 0);

        repeat (10) @(posedge clk_i);
        #1;
        check("all_expected_done_seen", 136'(q.size()), 136'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
